// File: rtl/cpu_commit_stage.sv
// Commit stage: performs the data-memory access for loads and stores,
// retires instructions through a single register-file write port, and
// publishes in-flight load information to the forwarding unit.
//
// state | meaning
// IDLE  | ready for a new instruction from execute
// REQ   | memory request presented, waiting for mem_req_ready
// WAIT  | load accepted by memory, waiting for mem_resp_valid
module cpu_commit_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_alu_result,
  input  logic [DATA_WIDTH-1:0]     in_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] in_reg_dest,
  input  logic                      in_reg_write,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_write,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  output logic [DATA_WIDTH-1:0]     mem_req_wdata,
  input  logic                      mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_resp_rdata,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_dest,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      fw_load_pending,
  output logic [REG_ADDR_WIDTH-1:0] fw_pending_reg,
  output logic [31:0]               retired_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                      reg_write_q, reg_write_d;
  logic                      is_load_q, is_load_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [REG_ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic [31:0]               retired_q, retired_d;

  // Next-state, operand latching and retirement bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dest_d      = dest_q;
    reg_write_d = reg_write_q;
    is_load_d   = is_load_q;
    wb_valid_d  = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    retired_d   = retired_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_mem_read || in_mem_write) begin
            addr_d      = in_alu_result[ADDR_WIDTH-1:0];
            wdata_d     = in_store_data;
            dest_d      = in_reg_dest;
            reg_write_d = in_reg_write;
            // A request flagged as both load and store is treated as a load.
            is_load_d   = in_mem_read;
            state_d     = REQ;
          end else begin
            wb_valid_d = in_reg_write && (in_reg_dest != '0);
            wb_dest_d  = in_reg_dest;
            wb_data_d  = in_alu_result;
            retired_d  = retired_q + 32'd1;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          if (is_load_q) begin
            state_d = WAIT;
          end else begin
            retired_d = retired_q + 32'd1;
            state_d   = IDLE;
          end
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          wb_valid_d = reg_write_q && (dest_q != '0);
          wb_dest_d  = dest_q;
          wb_data_d  = mem_resp_rdata;
          retired_d  = retired_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      is_load_q   <= is_load_d;
      wb_valid_q  <= wb_valid_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      retired_q   <= retired_d;
    end
  end

  // Outputs; in_ready is held low while reset is asserted so every output reads 0.
  always_comb begin
    in_ready        = (state_q == IDLE) && !reset;
    mem_req_valid   = (state_q == REQ);
    mem_req_write   = (state_q == REQ) && !is_load_q;
    mem_req_addr    = addr_q;
    mem_req_wdata   = wdata_q;
    wb_valid        = wb_valid_q;
    wb_reg_dest     = wb_dest_q;
    wb_data         = wb_data_q;
    fw_load_pending = (state_q != IDLE) && is_load_q;
    fw_pending_reg  = dest_q;
    retired_count   = retired_q;
  end

endmodule

// File: tb/tb_cpu_commit_stage.sv
// Directed bench for cpu_commit_stage: ALU retire, r0 suppression, stalled
// store, load with delayed response, spurious responses, reset mid-load.
module tb_cpu_commit_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [4:0]  in_reg_dest;
  logic        in_reg_write;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_reg_dest;
  logic [31:0] wb_data;
  logic        fw_load_pending;
  logic [4:0]  fw_pending_reg;
  logic [31:0] retired_count;

  int checks = 0;
  int errors = 0;

  cpu_commit_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_reg_dest(in_reg_dest), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .wb_valid(wb_valid), .wb_reg_dest(wb_reg_dest), .wb_data(wb_data),
    .fw_load_pending(fw_load_pending), .fw_pending_reg(fw_pending_reg),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_alu_result = 32'h0;
    in_store_data = 32'h0;
    in_reg_dest   = 5'd0;
    in_reg_write  = 1'b0;
    in_mem_read   = 1'b0;
    in_mem_write  = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    idle_inputs();
    step();
    step();
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_retired", retired_count, 32'd0);
    check("rst_fw", {31'd0, fw_load_pending}, 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ALU op to r3
    in_valid = 1'b1; in_alu_result = 32'h42; in_reg_dest = 5'd3; in_reg_write = 1'b1;
    step();
    idle_inputs();
    check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("alu_wb_dest", {27'd0, wb_reg_dest}, 32'd3);
    check("alu_wb_data", wb_data, 32'h42);
    check("alu_retired", retired_count, 32'd1);
    step();
    check("alu_wb_pulse_end", {31'd0, wb_valid}, 32'd0);

    // ALU op to r0: no write, but retires
    in_valid = 1'b1; in_alu_result = 32'h55; in_reg_dest = 5'd0; in_reg_write = 1'b1;
    step();
    idle_inputs();
    check("r0_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("r0_retired", retired_count, 32'd2);

    // Store stalled 3 cycles; spurious response and changing inputs in REQ
    in_valid = 1'b1; in_alu_result = 32'h100; in_store_data = 32'hDEADBEEF; in_mem_write = 1'b1;
    step();
    idle_inputs();
    in_alu_result  = 32'h999;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hFFFF;
    for (int i = 0; i < 3; i++) begin
      check("st_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("st_req_write", {31'd0, mem_req_write}, 32'd1);
      check("st_req_addr", mem_req_addr, 32'h100);
      check("st_req_wdata", mem_req_wdata, 32'hDEADBEEF);
      check("st_in_ready", {31'd0, in_ready}, 32'd0);
      check("st_fw", {31'd0, fw_load_pending}, 32'd0);
      check("st_no_wb", {31'd0, wb_valid}, 32'd0);
      step();
    end
    check("st_still_req", {31'd0, mem_req_valid}, 32'd1);
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("st_done_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("st_done_no_wb", {31'd0, wb_valid}, 32'd0);
    check("st_done_retired", retired_count, 32'd3);
    check("st_done_in_ready", {31'd0, in_ready}, 32'd1);

    // Load to r5, ready immediately, response after 4 cycles
    in_valid = 1'b1; in_alu_result = 32'h200; in_reg_dest = 5'd5; in_reg_write = 1'b1; in_mem_read = 1'b1;
    mem_req_ready = 1'b1;
    step();
    idle_inputs();
    check("ld_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("ld_req_write", {31'd0, mem_req_write}, 32'd0);
    check("ld_req_addr", mem_req_addr, 32'h200);
    check("ld_fw_pending", {31'd0, fw_load_pending}, 32'd1);
    check("ld_fw_reg", {27'd0, fw_pending_reg}, 32'd5);
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ld_wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check("ld_wait_fw", {31'd0, fw_load_pending}, 32'd1);
      check("ld_wait_fw_reg", {27'd0, fw_pending_reg}, 32'd5);
      check("ld_wait_in_ready", {31'd0, in_ready}, 32'd0);
      check("ld_wait_no_wb", {31'd0, wb_valid}, 32'd0);
      step();
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1234;
    step();
    mem_resp_valid = 1'b0;
    check("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("ld_wb_data", wb_data, 32'h1234);
    check("ld_wb_dest", {27'd0, wb_reg_dest}, 32'd5);
    check("ld_retired", retired_count, 32'd4);
    check("ld_fw_clear", {31'd0, fw_load_pending}, 32'd0);
    check("ld_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("ld_wb_pulse_end", {31'd0, wb_valid}, 32'd0);

    // Spurious response in IDLE
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hFFFF;
    step();
    step();
    mem_resp_valid = 1'b0;
    check("idle_resp_no_wb", {31'd0, wb_valid}, 32'd0);
    check("idle_resp_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_resp_retired", retired_count, 32'd4);

    // Read+write together acts as a load; then reset while in WAIT
    in_valid = 1'b1; in_alu_result = 32'h300; in_store_data = 32'h77; in_reg_dest = 5'd7;
    in_reg_write = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b1;
    step();
    idle_inputs();
    check("rw_req_write", {31'd0, mem_req_write}, 32'd0);
    check("rw_fw", {31'd0, fw_load_pending}, 32'd1);
    check("rw_fw_reg", {27'd0, fw_pending_reg}, 32'd7);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("rw_in_wait", {31'd0, fw_load_pending}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("mrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("mrst_wb_data", wb_data, 32'd0);
    check("mrst_wb_dest", {27'd0, wb_reg_dest}, 32'd0);
    check("mrst_fw", {31'd0, fw_load_pending}, 32'd0);
    check("mrst_retired", retired_count, 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hABCD;
    step();
    mem_resp_valid = 1'b0;
    check("mrst_late_resp_no_wb", {31'd0, wb_valid}, 32'd0);
    check("mrst_late_retired", retired_count, 32'd0);
    check("mrst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
